// File: rtl/sopc4_pwm_pkg.sv
// Shared types, control-word field layout and helpers for the sopc4 PWM generator.
// Optional complementary output with dead-band is enabled by SOPC4_PWM_COMPLEMENT_EN.
package sopc4_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default word layout: duty in the low half, period directly above it.
    localparam int unsigned DUTY_LSB   = 0;
    localparam int unsigned PERIOD_LSB = 16;

    // Ceiling log2 with a floor of 1 so degenerate counters still get a bit.
    function automatic int unsigned f_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sopc4_pwm_deadband.sv
// Splits the raw PWM into pwm_out / pwm_out_n, holding both low for DEADTIME clocks
// after every raw transition. Only instantiated with SOPC4_PWM_COMPLEMENT_EN.
module sopc4_pwm_deadband
    import sopc4_pwm_pkg::*;
#(
    parameter int unsigned DEADTIME = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pwm_out,
    output logic pwm_out_n
);

    localparam int unsigned DT_W    = f_clog2(DEADTIME + 1);
    localparam int unsigned DT_LOAD = (DEADTIME > 0) ? DEADTIME - 1 : 0;

    logic            raw_prev;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_nxt;
    logic            out_nxt;
    logic            out_n_nxt;

    // The detecting clock is the first of the DEADTIME low clocks.
    always_comb begin
        dt_nxt    = dt_cnt;
        out_nxt   = 1'b0;
        out_n_nxt = 1'b0;
        if ((raw != raw_prev) && (DEADTIME != 0)) begin
            dt_nxt = DT_W'(DT_LOAD);
        end else if (dt_cnt != '0) begin
            dt_nxt = dt_cnt - DT_W'(1);
        end else begin
            out_nxt   = raw;
            out_n_nxt = !raw;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_prev  <= 1'b0;
            dt_cnt    <= '0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            raw_prev  <= raw;
            dt_cnt    <= dt_nxt;
            pwm_out   <= out_nxt;
            pwm_out_n <= out_n_nxt;
        end
    end

endmodule

// File: rtl/sopc4_pwm_gen.sv
// PWM generator fed by the PIO {period, duty} word; settings take effect at period boundaries.
// Define SOPC4_PWM_COMPLEMENT_EN to add pwm_out_n with dead-band insertion.
module sopc4_pwm_gen
    import sopc4_pwm_pkg::*;
#(
    parameter int unsigned PERIOD_W  = PERIOD_LSB - DUTY_LSB,
    parameter int unsigned PRESC_DIV = 1,
    parameter int unsigned DEADTIME  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ctrl_word,
    output logic        pwm_out,
    output logic        period_end,
    output logic        running
`ifdef SOPC4_PWM_COMPLEMENT_EN
    ,
    output logic        pwm_out_n
`endif
);

    localparam int unsigned PRESC_W   = f_clog2(PRESC_DIV);
    localparam int unsigned PRESC_MAX = (PRESC_DIV > 0) ? PRESC_DIV - 1 : 0;

    // Elaboration-time guard against illegal configurations.
    if ((PRESC_DIV == 0) || (2 * PERIOD_W > 32) || (PERIOD_W == 0) || (DEADTIME > 65535)) begin : g_bad_cfg
        $error("sopc4_pwm_gen: illegal parameter set");
    end

    state_t              state;
    state_t              state_nxt;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [PRESC_W-1:0]  presc_nxt;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_nxt;
    logic [PERIOD_W-1:0] period_sh;
    logic [PERIOD_W-1:0] period_nxt;
    logic [PERIOD_W-1:0] duty_sh;
    logic [PERIOD_W-1:0] duty_nxt;
    logic                period_end_nxt;
    logic                running_nxt;
    logic                pwm_raw;
    logic                pwm_raw_nxt;

    logic [PERIOD_W-1:0] ctrl_period;
    logic [PERIOD_W-1:0] ctrl_duty;
    logic                tick;

    assign ctrl_period = ctrl_word[DUTY_LSB + PERIOD_W +: PERIOD_W];
    assign ctrl_duty   = ctrl_word[DUTY_LSB +: PERIOD_W];
    assign tick        = (presc_cnt == PRESC_W'(PRESC_MAX));

    // Next-state and output logic; shadows only reload on entry to RUN or at a boundary.
    always_comb begin
        state_nxt      = state;
        presc_nxt      = presc_cnt;
        cnt_nxt        = cnt;
        period_nxt     = period_sh;
        duty_nxt       = duty_sh;
        period_end_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                presc_nxt = '0;
                cnt_nxt   = '0;
                if (ctrl_period != '0) begin
                    period_nxt = ctrl_period;
                    duty_nxt   = ctrl_duty;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                presc_nxt = tick ? '0 : presc_cnt + PRESC_W'(1);
                if (tick) begin
                    if (cnt == period_sh - PERIOD_W'(1)) begin
                        cnt_nxt        = '0;
                        period_end_nxt = 1'b1;
                        period_nxt     = ctrl_period;
                        duty_nxt       = ctrl_duty;
                        if (ctrl_period == '0) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + PERIOD_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        running_nxt = (state_nxt == RUN);
        pwm_raw_nxt = (state == RUN) && (cnt < duty_sh);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc_cnt  <= '0;
            cnt        <= '0;
            period_sh  <= '0;
            duty_sh    <= '0;
            period_end <= 1'b0;
            running    <= 1'b0;
            pwm_raw    <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc_cnt  <= presc_nxt;
            cnt        <= cnt_nxt;
            period_sh  <= period_nxt;
            duty_sh    <= duty_nxt;
            period_end <= period_end_nxt;
            running    <= running_nxt;
            pwm_raw    <= pwm_raw_nxt;
        end
    end

`ifdef SOPC4_PWM_COMPLEMENT_EN
    sopc4_pwm_deadband #(
        .DEADTIME (DEADTIME)
    ) u_deadband (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (pwm_raw),
        .pwm_out   (pwm_out),
        .pwm_out_n (pwm_out_n)
    );
`else
    assign pwm_out = pwm_raw;
`endif

endmodule

// File: tb/tb_sopc4_pwm_gen.sv
// Self-checking bench for sopc4_pwm_gen: directed vector table, corner sequences and
// randomized ctrl words checked against an elapsed-time reference model.
module tb_sopc4_pwm_gen;

    logic        clk = 1'b0;
    logic        rst1_n;
    logic        rst3_n;
    logic [31:0] ctrl1;
    logic [31:0] ctrl3;
    logic        pwm1, pe1, run1;
    logic        pwm3, pe3, run3;
`ifdef SOPC4_PWM_COMPLEMENT_EN
    logic        pwm1_n, pwm3_n;
`endif

    always #5 clk = ~clk;

    sopc4_pwm_gen #(.PERIOD_W(16), .PRESC_DIV(1), .DEADTIME(2)) dut1 (
        .clk        (clk),
        .reset_n    (rst1_n),
        .ctrl_word  (ctrl1),
        .pwm_out    (pwm1),
        .period_end (pe1),
        .running    (run1)
`ifdef SOPC4_PWM_COMPLEMENT_EN
        ,
        .pwm_out_n  (pwm1_n)
`endif
    );

    sopc4_pwm_gen #(.PERIOD_W(16), .PRESC_DIV(3), .DEADTIME(2)) dut3 (
        .clk        (clk),
        .reset_n    (rst3_n),
        .ctrl_word  (ctrl3),
        .pwm_out    (pwm3),
        .period_end (pe3),
        .running    (run3)
`ifdef SOPC4_PWM_COMPLEMENT_EN
        ,
        .pwm_out_n  (pwm3_n)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Reference model: time measured in clocks elapsed since the period started.
    bit          m_run  [2];
    int unsigned m_el   [2];
    int unsigned m_per  [2];
    int unsigned m_duty [2];
    bit          e_pwm  [2];
    bit          e_pe   [2];
    bit          e_run  [2];

    task automatic model_reset(input int i);
        m_run[i] = 0; m_el[i] = 0; m_per[i] = 0; m_duty[i] = 0;
        e_pwm[i] = 0; e_pe[i] = 0; e_run[i] = 0;
    endtask

    task automatic model_step(input int i, input bit rst_n, input logic [31:0] w);
        int unsigned p;
        int unsigned wp;
        int unsigned wd;
        bit          bnd;
        p  = (i == 0) ? 1 : 3;
        wp = int'(w[31:16]);
        wd = int'(w[15:0]);
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        bnd      = m_run[i] && (m_el[i] == m_per[i] * p - 1);
        e_pwm[i] = m_run[i] && ((m_el[i] / p) < m_duty[i]);
        e_pe[i]  = bnd;
        if (!m_run[i]) begin
            if (wp != 0) begin
                m_run[i] = 1; m_per[i] = wp; m_duty[i] = wd; m_el[i] = 0;
            end
        end else if (bnd) begin
            m_el[i] = 0; m_per[i] = wp; m_duty[i] = wd;
            if (wp == 0) m_run[i] = 0;
        end else begin
            m_el[i]++;
        end
        e_run[i] = m_run[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step(0, rst1_n, ctrl1);
        model_step(1, rst3_n, ctrl3);
        #1;
`ifndef SOPC4_PWM_COMPLEMENT_EN
        chk("m1_pwm", 32'(pwm1), 32'(e_pwm[0]));
        chk("m3_pwm", 32'(pwm3), 32'(e_pwm[1]));
`else
        chk("m1_overlap", 32'(pwm1 & pwm1_n), 32'd0);
        chk("m3_overlap", 32'(pwm3 & pwm3_n), 32'd0);
`endif
        chk("m1_pe",  32'(pe1),  32'(e_pe[0]));
        chk("m1_run", 32'(run1), 32'(e_run[0]));
        chk("m3_pe",  32'(pe3),  32'(e_pe[1]));
        chk("m3_run", 32'(run3), 32'(e_run[1]));
    endtask

    typedef struct {
        logic [31:0] ctrl;
        bit          pwm;
        bit          pe;
        bit          run;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int lows;
        int highs;
        int found;
        int pe_a;
        int pe_b;

        // Period 4: duty 1, then duty 3 written at cnt=1, then stop with word 0.
        vecs[0]  = '{32'h0004_0001, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'h0004_0001, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h0004_0001, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h0004_0001, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h0004_0001, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{32'h0004_0001, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h0004_0003, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h0004_0003, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h0004_0003, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h0004_0003, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h0004_0003, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'h0004_0003, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{32'h0004_0003, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{32'h0004_0003, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0};

        model_reset(0);
        model_reset(1);
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        ctrl1  = 32'h0004_0001;
        ctrl3  = 32'h0002_0001;
        repeat (3) cycle();
        chk("rst_pwm",  32'(pwm1), 32'd0);
        chk("rst_pe",   32'(pe1),  32'd0);
        chk("rst_run",  32'(run1), 32'd0);
        chk("rst3_run", 32'(run3), 32'd0);

        ctrl1  = 32'h0;
        ctrl3  = 32'h0;
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        cycle();

        for (int k = 0; k < 18; k++) begin
            ctrl1 = vecs[k].ctrl;
            cycle();
`ifndef SOPC4_PWM_COMPLEMENT_EN
            chk($sformatf("vec%0d_pwm", k), 32'(pwm1), 32'(vecs[k].pwm));
`endif
            chk($sformatf("vec%0d_pe", k),  32'(pe1),  32'(vecs[k].pe));
            chk($sformatf("vec%0d_run", k), 32'(run1), 32'(vecs[k].run));
        end

        // 0% duty stays low, then 100% duty never dips across the wrap.
        ctrl1 = 32'h0005_0000;
        lows  = 0;
        highs = 0;
        repeat (12) begin
            cycle();
            highs += int'(pwm1);
        end
        chk("zero_duty_highs", 32'(highs), 32'd0);
        ctrl1 = 32'h0005_0007;
        found = 0;
        repeat (25) begin
            cycle();
            if (pwm1) found = 1;
            else if (found != 0) lows++;
        end
`ifndef SOPC4_PWM_COMPLEMENT_EN
        chk("full_duty_seen", 32'(found), 32'd1);
        chk("full_duty_gap",  32'(lows),  32'd0);
`endif
        ctrl1 = 32'h0;
        repeat (8) cycle();

        // Prescaled run, async reset mid-high, restart from cnt=0.
        ctrl3 = 32'h0002_0001;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            cycle();
            if (pwm3) found = 1;
        end
        chk("presc_first_high", 32'(found), 32'd1);
        cycle();
        rst3_n = 1'b0;
        #1;
        model_reset(1);
        chk("async_rst_pwm", 32'(pwm3), 32'd0);
        chk("async_rst_run", 32'(run3), 32'd0);
        repeat (2) cycle();
        rst3_n = 1'b1;
        pe_a   = -1;
        pe_b   = -1;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (pe3) begin
                if (pe_a < 0) pe_a = k;
                else if (pe_b < 0) pe_b = k;
            end
        end
        chk("presc_pe_spacing", 32'(pe_b - pe_a), 32'd6);
        // Restart: run at edge 1, first pe at edge 1+6.
        chk("presc_first_pe", 32'(pe_a), 32'd6);

        // Randomized words, occasional resets, both prescaler settings.
        for (int k = 0; k < 1500; k++) begin
            if (rst1_n == 1'b0) rst1_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst1_n = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                ctrl1[31:16] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
                ctrl1[15:0]  = 16'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 7) == 0) begin
                ctrl3[31:16] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
                ctrl3[15:0]  = 16'($urandom_range(0, 8));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sopc4_pwm_gen.md
Name: sopc4_pwm_gen

Overview:
Downstream consumer of the 32-bit PIO output word (s1 out_port) in the sopc4 system. It interprets the word as {period, duty} and produces a glitch-free PWM waveform. New settings are captured into shadow registers only at period boundaries. Sits between the PIO out_port and the board pin, or the LED/motor driver.

Parameters:
PERIOD_W, 16, width of the period and duty fields; ctrl_word[2*PERIOD_W-1:PERIOD_W] is period, [PERIOD_W-1:0] is duty; 2*PERIOD_W must be <= 32.
PRESC_DIV, 1, clock cycles per PWM count tick; legal range >= 1.
DEADTIME, 2, cycles both outputs are held low at each edge; used only with PWM_COMPLEMENT_EN.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ctrl_word  input  32  {period, duty} word, driven straight from the PIO out_port; clk domain
pwm_out  output  1  registered PWM output
period_end  output  1  one-clock pulse on the last tick of each period
running  output  1  high while the FSM is in RUN

Behaviour:
- Reset: state=IDLE. presc_cnt, cnt, period_sh, duty_sh, pwm_out, period_end, running all 0. Reset is honoured mid-period; the output drops low immediately (asynchronously).
- Prescaler: in RUN, presc_cnt counts 0..PRESC_DIV-1. tick=(presc_cnt==PRESC_DIV-1). With PRESC_DIV=1, tick is every clock. presc_cnt is held at 0 in IDLE.
- FSM IDLE: if period field != 0, then on the next edge:
  - load period_sh and duty_sh from ctrl_word;
  - clear cnt and presc_cnt;
  - go to RUN.
  Otherwise stay in IDLE.
- FSM RUN: on tick, cnt increments. When cnt==period_sh-1 on a tick (boundary):
  - cnt<=0;
  - period_end<=1 for exactly one clock;
  - shadows reload from the current ctrl_word;
  - if the reloaded period==0, go to IDLE.
- Mid-period ctrl_word changes are ignored until the boundary. There is no RUN->IDLE transition except at a boundary or by reset.
- pwm_out is registered: next = (state==RUN) && (cnt < duty_sh). It therefore lags cnt by one clock.
- First high cycle appears 2 clocks after ctrl_word becomes valid in IDLE: 1 clock for IDLE->RUN, 1 clock for the output register.
- Duty rules:
  - duty_sh==0 gives constant low;
  - duty_sh>=period_sh gives constant high (100%, no low gap at wrap);
  - otherwise high for duty_sh ticks out of period_sh.
- period_sh==1 is legal: every tick is a boundary.
- Arithmetic: cnt is PERIOD_W bits and is unsigned throughout. Compares are unsigned. No overflow is possible because cnt < period_sh <= 2^PERIOD_W-1.
- running is a registered copy of (state==RUN), updated on the same edge as the state.

Optional Feature:
Macro SOPC4_PWM_COMPLEMENT_EN.
- Defined: adds output port pwm_out_n (1 bit, reset 0), the complement of the raw PWM signal with dead-band insertion.
  - After any raw transition, both pwm_out and pwm_out_n are forced low for DEADTIME clocks. Then the newly active side asserts.
  - A 0% or 100% duty holds one side permanently active with no dead-band.
  - A deadtime counter of width clog2(DEADTIME+1) is reset to 0.
- Undefined: the port, counter and logic are absent. pwm_out is as described in Behaviour.

Decomposition:
- Package sopc4_pwm_pkg holds:
  - typedef state_t {IDLE, RUN};
  - field-slice localparams PERIOD_LSB and DUTY_LSB;
  - function f_clog2.
- One sub-module, sopc4_pwm_deadband, contains the dead-band generator (raw in, pwm_out/pwm_out_n out, DEADTIME parameter). It is instantiated only under SOPC4_PWM_COMPLEMENT_EN.

Test Plan:
- PRESC_DIV=1, ctrl_word=0x0004_0001 -> running=1 after 1 clk. pwm_out pattern 1,0,0,0 repeating, first 1 at clk 2. period_end pulses every 4 clks.
- In RUN at period 4 / duty 1, write 0x0004_0003 at cnt=1 -> current period keeps duty 1. Next period is high 3 / low 1, aligned to the period_end pulse.
- ctrl_word=0x0005_0000 -> pwm_out constant 0. Then 0x0005_0007 -> pwm_out constant 1 with no low glitch across the wrap.
- In RUN, write ctrl_word=0 -> pwm_out continues to the boundary, then running=0 and pwm_out=0 one clk later. period_end asserts once.
- PRESC_DIV=3, 0x0002_0001 -> high 3 clks, low 3 clks; period_end every 6 clks. Assert reset_n low mid-high -> pwm_out=0 immediately and state IDLE. On release with the same word, the waveform restarts from cnt=0.
- With SOPC4_PWM_COMPLEMENT_EN, DEADTIME=2, 0x0008_0004 -> pwm_out and pwm_out_n are never both 1. Each shows a 2-clk both-low gap at every edge.
